// File: rtl/window_envelope_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_envelope_detector_pkg
// Description : Shared receiver-path definitions. Holds the default sample
//               width, the default window length, the envelope/threshold
//               widths and the unsigned envelope typedef used by both the
//               envelope detector and the downstream threshold tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package window_envelope_detector_pkg;

   // Default signed receiver sample width.
   localparam int c_RX_IW     = 16;
   // Default samples per envelope window.
   localparam int c_RX_WINDOW = 256;
   // Threshold width of the tracker; it compares directly against envelopes.
   localparam int c_RX_TW     = c_RX_IW;

   // Unsigned envelope value as seen by the threshold tracker.
   typedef logic [c_RX_IW-1:0] env_t;
   // Threshold value in the tracker.
   typedef logic [c_RX_TW-1:0] thresh_t;

   // True when v is a non-zero power of two. Usable at elaboration time.
   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage : window_envelope_detector_pkg
`default_nettype wire

// File: rtl/window_envelope_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : window_envelope_detector_if
// Description : Sample-in / envelope-out bundle of the envelope detector.
//               master : sample source (drives samples and clear, observes
//                        the envelope result)
//               slave  : the detector (consumes samples, drives results)
// Signals     : clr_i          abort current window
//               sample_i       signed sample, IW bits
//               sample_valid_i sample_i valid this cycle
//               env_o          mean |sample| of last completed window
//               peak_o         max  |sample| of last completed window
//               valid_o        one-cycle pulse, env_o/peak_o updated
// Revision    : 1.0 - initial release
// ============================================================================
interface window_envelope_detector_if #(
   parameter int IW = window_envelope_detector_pkg::c_RX_IW
) ();

   logic                 clr_i;
   logic signed [IW-1:0] sample_i;
   logic                 sample_valid_i;
   logic        [IW-1:0] env_o;
   logic        [IW-1:0] peak_o;
   logic                 valid_o;

   modport master (
      output clr_i,
      output sample_i,
      output sample_valid_i,
      input  env_o,
      input  peak_o,
      input  valid_o
   );

   modport slave (
      input  clr_i,
      input  sample_i,
      input  sample_valid_i,
      output env_o,
      output peak_o,
      output valid_o
   );

endinterface : window_envelope_detector_if
`default_nettype wire

// File: rtl/window_envelope_detector_sample_abs.sv
`default_nettype none
// ============================================================================
// Module      : window_envelope_detector_sample_abs
// Description : Registered signed-to-unsigned magnitude with valid
//               passthrough. The magnitude of the most negative input,
//               2^(IW-1), is representable in IW unsigned bits, so no
//               saturation is needed.
// Ports       : clk      system clock
//               rst      synchronous active-high reset
//               i_clr    drop the sample presented this cycle
//               i_sample signed sample
//               i_valid  i_sample valid this cycle
//               o_mag    registered |i_sample|, unsigned IW bits
//               o_valid  o_mag valid this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module window_envelope_detector_sample_abs #(
   parameter int IW = 16
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 i_clr,
   input  wire logic signed [IW-1:0] i_sample,
   input  wire logic                 i_valid,
   output      logic        [IW-1:0] o_mag,
   output      logic                 o_valid
);

   logic [IW-1:0] w_mag;
   logic [IW-1:0] r_mag;
   logic          r_valid;

   // Two's-complement negate on the raw bits; for -2^(IW-1) this yields the
   // same bit pattern, which read unsigned is exactly 2^(IW-1).
   always_comb begin
      w_mag = $unsigned(i_sample);
      if (i_sample[IW-1]) begin
         w_mag = ~$unsigned(i_sample) + {{(IW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_mag   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_mag <= w_mag;
         end
      end
   end

   assign o_mag   = r_mag;
   assign o_valid = r_valid;

endmodule : window_envelope_detector_sample_abs
`default_nettype wire

// File: rtl/window_envelope_detector.sv
`default_nettype none
// ============================================================================
// Module      : window_envelope_detector
// Description : Converts raw signed receiver samples into a windowed envelope
//               (mean absolute value over WINDOW samples) plus the window
//               peak magnitude. One single-cycle valid_o pulse per completed
//               window; results hold between pulses.
// Ports       : clk  system clock
//               rst  synchronous active-high reset
//               bus  slave side of window_envelope_detector_if
//                    (clr_i, sample_i, sample_valid_i in;
//                     env_o, peak_o, valid_o out)
// Revision    : 1.0 - initial release
// ============================================================================
module window_envelope_detector
   import window_envelope_detector_pkg::*;
#(
   parameter int IW     = c_RX_IW,
   parameter int WINDOW = c_RX_WINDOW
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   window_envelope_detector_if.slave bus
);

   localparam int LW = $clog2(WINDOW);
   localparam int AW = IW + LW;
   localparam logic [LW-1:0] c_CNT_LAST = LW'(WINDOW - 1);

   generate
      if ((WINDOW < 2) || !is_pow2(WINDOW)) begin : g_window_check
         $error("window_envelope_detector: WINDOW must be a power of two >= 2");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Stage 1: magnitude
   // ------------------------------------------------------------------------
   logic [IW-1:0] w_mag;
   logic          w_mag_valid;

   window_envelope_detector_sample_abs #(
      .IW (IW)
   ) u_sample_abs (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (bus.clr_i),
      .i_sample (bus.sample_i),
      .i_valid  (bus.sample_valid_i),
      .o_mag    (w_mag),
      .o_valid  (w_mag_valid)
   );

   // ------------------------------------------------------------------------
   // Stage 2: accumulate, peak and window count
   // ------------------------------------------------------------------------
   logic [AW-1:0] r_acc;
   logic [IW-1:0] r_run_peak;
   logic [LW-1:0] r_cnt;
   logic [IW-1:0] r_env;
   logic [IW-1:0] r_peak;
   logic          r_valid;

   // Sum split so the high part is directly the mean (divide by WINDOW).
   // WINDOW * 2^(IW-1) fits in AW bits, so the sum cannot overflow.
   logic [IW-1:0] w_sum_hi;
   logic [LW-1:0] w_sum_lo;
   logic [IW-1:0] w_peak_next;
   logic          w_last;

   assign {w_sum_hi, w_sum_lo} = r_acc + {{LW{1'b0}}, w_mag};
   assign w_peak_next          = (w_mag > r_run_peak) ? w_mag : r_run_peak;
   assign w_last               = (r_cnt == c_CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= '0;
         r_run_peak <= '0;
         r_cnt      <= '0;
         r_env      <= '0;
         r_peak     <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         // Clear wins over an in-flight magnitude and suppresses any
         // completion it would have produced; results keep their values.
         if (bus.clr_i) begin
            r_acc      <= '0;
            r_run_peak <= '0;
            r_cnt      <= '0;
         end else if (w_mag_valid) begin
            if (w_last) begin
               r_env      <= w_sum_hi;
               r_peak     <= w_peak_next;
               r_valid    <= 1'b1;
               r_acc      <= '0;
               r_run_peak <= '0;
               r_cnt      <= '0;
            end else begin
               r_acc      <= {w_sum_hi, w_sum_lo};
               r_run_peak <= w_peak_next;
               r_cnt      <= r_cnt + {{(LW-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign bus.env_o   = r_env;
   assign bus.peak_o  = r_peak;
   assign bus.valid_o = r_valid;

endmodule : window_envelope_detector
`default_nettype wire

// File: doc/window_envelope_detector.md
Name: window_envelope_detector

Overview:
- Upstream stage of the threshold tracker. Converts raw signed receiver samples into a windowed envelope (mean absolute value) plus a window peak.
- Emits one single-cycle `valid_o` pulse per completed window.
- `env_o`/`valid_o` connect directly to the tracker's `signal_i`/`valid_i`. `peak_o` goes to status/debug logic.

Parameters:
- IW, 16, width of signed input sample (two's complement).
- WINDOW, 256, samples per window. Must be a power of two, ≥2; elaborate-time assertion on violation.
- LW, $clog2(WINDOW), derived (localparam); shift amount and window-counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- clr_i  input  1  abort current window, discard partial accumulation.
- sample_i  input  IW  signed sample.
- sample_valid_i  input  1  sample_i valid this cycle.
- env_o  output  IW  unsigned mean |sample| of last completed window.
- peak_o  output  IW  unsigned max |sample| of last completed window.
- valid_o  output  1  one-cycle pulse; env_o/peak_o updated this cycle.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high, evaluated on the rising edge of clk.
  - Reset values: env_o=0, peak_o=0, valid_o=0, window count=0, accumulator=0, running peak=0, magnitude stage invalid.
- Stage 1 (magnitude):
  - On sample_valid_i, register mag = |sample_i| as IW-bit unsigned and set mag_valid.
  - |−2^(IW−1)| = 2^(IW−1) fits in IW unsigned bits; no saturation.
  - mag_valid clears when sample_valid_i=0.
- Stage 2 (accumulate), on mag_valid:
  - acc += mag. Accumulator width IW+LW; cannot overflow.
  - run_peak = max(run_peak, mag).
  - cnt += 1. cnt is LW bits and wraps WINDOW−1 → 0.
- Window completion:
  - When mag_valid and cnt==WINDOW−1, the next cycle registers:
    - env_o = (acc+mag) >> LW, truncated to IW bits;
    - peak_o = max(run_peak, mag);
    - valid_o=1.
  - In the same update, acc, run_peak and cnt restart at 0. Nothing carries over between windows.
- Latency: valid_o asserts exactly 2 cycles after the cycle the WINDOW-th sample is presented. Gaps in sample_valid_i stretch the window; they do not affect results.
- Back-to-back windows: continuous valid input → one pulse every WINDOW cycles. A sample arriving in the cycle the previous window closes counts as sample 0 of the new window.
- Hold: env_o/peak_o hold their values between pulses. valid_o is never high two cycles in a row unless WINDOW samples were accepted between.
- clr_i (priority over sample data):
  - Next cycle: cnt=0, acc=0, run_peak=0, mag_valid=0.
  - A sample presented with clr_i high is dropped. An in-flight magnitude is dropped.
  - A completion that would have fired is suppressed (valid_o=0).
  - env_o/peak_o keep their last values.
- Reset mid-window: same as clr_i, but outputs also return to 0.

Decomposition:
- Shared receiver package holds: sample width constant (IW default), default window length, and a typedef for unsigned envelope values. Both this block and the threshold tracker use the envelope typedef and threshold width.
- Sub-module sample_abs: registered signed→unsigned magnitude with valid passthrough; reusable by other envelope paths.
- Accumulator, peak and counter logic stay in the top module.

Test Plan (IW=8, WINDOW=4):
- Reset → env_o=0, peak_o=0, valid_o=0. Hold rst over a half-filled window → no pulse afterwards until 4 fresh samples.
- Consecutive 10, −20, 30, −40 → valid_o high for exactly one cycle, 2 cycles after −40, with env_o=25 and peak_o=40.
- Four samples of −128 → env_o=128, peak_o=128; checks the most-negative edge case with no wrap.
- Samples 3, 5, 7, 9 with 0–5 idle cycles randomly interleaved → env_o=6, peak_o=9; pulse exactly 2 cycles after the 9.
- Two samples of 100, clr_i, then four samples of 8 → a single pulse with env_o=8, peak_o=8. clr_i asserted together with a sample → that sample is excluded.
- Eight continuous samples (1,1,1,1 then 4,4,4,4) → two pulses 4 cycles apart: env 1/peak 1, then env 4/peak 4. Confirms no carry-over between windows.
